// File: rtl/trig_cond_pkg.sv
// Shared definitions for the trigger conditioner: FSM state encodings and
// default timing constants.
package trig_cond_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        QUAL_HI = 2'b01,
        HIGH    = 2'b10,
        QUAL_LO = 2'b11
    } tc_state_e;

    localparam int DB_CYCLES_DEF = 4;
    localparam int LOCKOUT_DEF   = 6;

endpackage

// File: rtl/trig_conditioner_sync2.sv
// Two-flop synchroniser for a single asynchronous bit, synchronous
// active-high reset clears both stages.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw bit through two flops so only q is used downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/trig_conditioner.sv
// Trigger conditioner: synchronises raw_in, debounces it over DB_CYCLES
// consecutive samples and emits a one-cycle trig_out on each qualified rise.
// Optional feature macro: TRIG_LOCKOUT_EN adds a post-trigger lockout of
// LOCKOUT cycles during which qualified rises do not pulse trig_out.
//
// trig_out is a strobe with no back-pressure: a 1 means "one trigger, this
// cycle only"; the consumer must take it when it appears.
module trig_conditioner
    import trig_cond_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int LOCKOUT   = LOCKOUT_DEF,
    parameter int GLITCH_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                raw_in,
    output logic                trig_out,
    output logic                level_out,
    output logic [1:0]          state,
    output logic [GLITCH_W-1:0] glitch_cnt,
    output logic                busy
);

    localparam int            QW      = $clog2(DB_CYCLES + 1);
    localparam logic [QW-1:0] DB_LAST = QW'(DB_CYCLES - 1);
    localparam bit            DB_ONE  = (DB_CYCLES == 1);

    logic          sync_q;
    tc_state_e     state_q, state_d;
    logic [QW-1:0] q_cnt, q_d;
    logic          rise_d;
    logic          glitch_d;
    logic          trig_d;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (sync_q)
    );

    // State register plus the counters and the registered trigger strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            q_cnt      <= '0;
            trig_out   <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            state_q  <= state_d;
            q_cnt    <= q_d;
            trig_out <= trig_d;
            if (glitch_d && (glitch_cnt != {GLITCH_W{1'b1}}))
                glitch_cnt <= glitch_cnt + GLITCH_W'(1);
        end
    end

    // Next-state logic: qualify each level change over DB_CYCLES samples
    always_comb begin
        state_d  = state_q;
        q_d      = q_cnt;
        rise_d   = 1'b0;
        glitch_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_q) begin
                    if (DB_ONE) begin
                        state_d = HIGH;
                        q_d     = '0;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = QUAL_HI;
                        q_d     = QW'(1);
                    end
                end
            end
            QUAL_HI: begin
                if (!sync_q) begin
                    state_d  = IDLE;
                    q_d      = '0;
                    glitch_d = 1'b1;
                end else if (q_cnt == DB_LAST) begin
                    state_d = HIGH;
                    q_d     = '0;
                    rise_d  = 1'b1;
                end else begin
                    q_d = q_cnt + QW'(1);
                end
            end
            HIGH: begin
                if (!sync_q) begin
                    if (DB_ONE) begin
                        state_d = IDLE;
                        q_d     = '0;
                    end else begin
                        state_d = QUAL_LO;
                        q_d     = QW'(1);
                    end
                end
            end
            QUAL_LO: begin
                if (sync_q) begin
                    // Level bounced back before the fall qualified: no pulse
                    state_d  = HIGH;
                    q_d      = '0;
                    glitch_d = 1'b1;
                end else if (q_cnt == DB_LAST) begin
                    state_d = IDLE;
                    q_d     = '0;
                end else begin
                    q_d = q_cnt + QW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                q_d     = '0;
            end
        endcase
    end

    // Output logic decoded from the registered state
    always_comb begin
        level_out = (state_q == HIGH) || (state_q == QUAL_LO);
        state     = state_q;
    end

`ifdef TRIG_LOCKOUT_EN
    localparam int LW = $clog2(LOCKOUT + 1);

    logic [LW-1:0] lock_cnt;

    // busy reflects the count before this edge's load, so a qualification
    // landing on the expiry edge (count already 0) still fires
    assign busy   = (lock_cnt != '0);
    assign trig_d = rise_d && !busy;

    // Lockout counter: reload on each emitted trigger, count down to zero
    always_ff @(posedge clk) begin
        if (rst)
            lock_cnt <= '0;
        else if (trig_d)
            lock_cnt <= LW'(LOCKOUT);
        else if (lock_cnt != '0)
            lock_cnt <= lock_cnt - LW'(1);
    end
`else
    // LOCKOUT only matters when lockout is built in; consume it here
    logic unused_lockout;

    assign unused_lockout = (LOCKOUT != 0);
    assign busy           = 1'b0;
    assign trig_d         = rise_d;
`endif

endmodule

// File: tb/tb_trig_conditioner.sv
// Bench for trig_conditioner: a DB_CYCLES=4 instance for debounce, glitch,
// saturation and reset checks, and a DB_CYCLES=1 instance for lockout.
// Expected trigger cycles are queued by the stimulus and consumed by
// per-instance monitors that fire whenever trig_out is seen high.
module tb_trig_conditioner;
    import trig_cond_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst4, raw4, trig4, level4, busy4;
    logic [1:0] state4;
    logic [7:0] glitch4;
    logic       rst1, raw1, trig1, level1, busy1;
    logic [1:0] state1;
    logic [7:0] glitch1;

    trig_conditioner #(.DB_CYCLES(4), .LOCKOUT(6), .GLITCH_W(8)) dut4 (
        .clk(clk), .rst(rst4), .raw_in(raw4), .trig_out(trig4),
        .level_out(level4), .state(state4), .glitch_cnt(glitch4), .busy(busy4)
    );

    trig_conditioner #(.DB_CYCLES(1), .LOCKOUT(6), .GLITCH_W(8)) dut1 (
        .clk(clk), .rst(rst1), .raw_in(raw1), .trig_out(trig1),
        .level_out(level1), .state(state1), .glitch_cnt(glitch1), .busy(busy1)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [31:0] exp4_q[$];
    logic [31:0] exp1_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic prev4 = 1'b0;
    logic prev1 = 1'b0;

    // Monitor for the DB_CYCLES=4 instance
    always @(negedge clk) begin
        if (trig4) begin
            check("trig4_single_cycle", prev4, 0);
            if (exp4_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL trig4_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                check("trig4_cycle", cyc, exp4_q.pop_front());
            end
        end
        prev4 = trig4;
    end

    // Monitor for the DB_CYCLES=1 instance
    always @(negedge clk) begin
        if (trig1) begin
            check("trig1_single_cycle", prev1, 0);
            if (exp1_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL trig1_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                check("trig1_cycle", cyc, exp1_q.pop_front());
            end
        end
        prev1 = trig1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drive raw4 at a negedge; returns the edge that first samples it
    task automatic drive4(input logic v, output int edge_n);
        raw4   = v;
        edge_n = cyc + 1;
    endtask

    task automatic drive1(input logic v, output int edge_n);
        raw1   = v;
        edge_n = cyc + 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e, f, g, h, r, e2;
        logic exp_busy;

        rst4 = 1'b1; raw4 = 1'b0;
        rst1 = 1'b1; raw1 = 1'b0;
        tick(3);
        rst4 = 1'b0; rst1 = 1'b0;
        tick(2);

        // Reset state
        check("rst_trig",   trig4,   0);
        check("rst_level",  level4,  0);
        check("rst_state",  state4,  IDLE);
        check("rst_glitch", glitch4, 0);
        check("rst_busy",   busy4,   0);
        check("rst1_state", state1,  IDLE);
        check("rst1_busy",  busy1,   0);

        // Clean rise: trigger rises at E+1+4
        drive4(1'b1, e);
        exp4_q.push_back(e + 5);
        wait_cyc(e + 4);
        check("rise_level_before", level4, 0);
        check("rise_state_before", state4, QUAL_HI);
        wait_cyc(e + 5);
        check("rise_level", level4, 1);
        check("rise_state", state4, HIGH);
        tick(3);
        check("rise_glitch", glitch4, 0);

        // Glitch during fall: low for two samples, then high again
        drive4(1'b0, f);
        tick(2);
        raw4 = 1'b1;
        wait_cyc(f + 3);
        check("fall_glitch_state_mid", state4, QUAL_LO);
        check("fall_glitch_level_mid", level4, 1);
        wait_cyc(f + 5);
        check("fall_glitch_state", state4, HIGH);
        check("fall_glitch_level", level4, 1);
        check("fall_glitch_cnt",   glitch4, 1);

        // Qualified fall: level drops DB_CYCLES edges after sync_q falls
        tick(2);
        drive4(1'b0, g);
        wait_cyc(g + 4);
        check("fall_level_before", level4, 1);
        wait_cyc(g + 5);
        check("fall_level", level4, 0);
        check("fall_state", state4, IDLE);

        // Short glitch on the rising side
        tick(2);
        drive4(1'b1, h);
        tick(2);
        raw4 = 1'b0;
        wait_cyc(h + 3);
        check("short_state_mid", state4, QUAL_HI);
        wait_cyc(h + 5);
        check("short_state",  state4, IDLE);
        check("short_glitch", glitch4, 2);
        check("short_level",  level4, 0);

        // Saturation: 300 more short glitches on top of the 2 already counted
        for (int i = 0; i < 300; i++) begin
            raw4 = 1'b1;
            tick(2);
            raw4 = 1'b0;
            tick(4);
            if (i == 251) check("sat_254", glitch4, 254);
            if (i == 252) check("sat_255", glitch4, 255);
        end
        check("sat_hold",  glitch4, 255);
        check("sat_state", state4, IDLE);

        // Reset during QUAL_HI with raw_in held high
        drive4(1'b1, r);
        wait_cyc(r + 3);
        check("mid_rst_state_before", state4, QUAL_HI);
        rst4 = 1'b1;
        tick(1);
        check("mid_rst_trig",   trig4,   0);
        check("mid_rst_level",  level4,  0);
        check("mid_rst_state",  state4,  IDLE);
        check("mid_rst_glitch", glitch4, 0);
        check("mid_rst_busy",   busy4,   0);
        rst4 = 1'b0;
        exp4_q.push_back(r + 10);
        wait_cyc(r + 9);
        check("mid_rst_level_before", level4, 0);
        wait_cyc(r + 10);
        check("mid_rst_level_after", level4, 1);
        raw4 = 1'b0;
        tick(8);

        // Lockout: two qualified rises 4 cycles apart with DB_CYCLES=1
        drive1(1'b1, e);
        exp1_q.push_back(e + 2);
`ifndef TRIG_LOCKOUT_EN
        exp1_q.push_back(e + 6);
`endif
        for (int c = e + 1; c <= e + 8; c++) begin
            wait_cyc(c);
`ifdef TRIG_LOCKOUT_EN
            exp_busy = (c >= e + 2) && (c <= e + 7);
`else
            exp_busy = 1'b0;
`endif
            check("lock_busy", busy1, exp_busy);
            if (c == e + 5) begin
                check("lock_gap_state", state1, IDLE);
                check("lock_gap_level", level1, 0);
            end
            if (c == e + 6) begin
                check("lock_second_state", state1, HIGH);
                check("lock_second_level", level1, 1);
            end
            if (c == e + 2) raw1 = 1'b0;
            if (c == e + 3) raw1 = 1'b1;
        end

        // A rise well after expiry always triggers
        raw1 = 1'b0;
        tick(4);
        drive1(1'b1, e2);
        exp1_q.push_back(e2 + 2);
        wait_cyc(e2 + 2);
`ifdef TRIG_LOCKOUT_EN
        check("late_busy", busy1, 1);
`else
        check("late_busy", busy1, 0);
`endif
        check("late_level", level1, 1);
        raw1 = 1'b0;
        tick(8);

        // ---------------- final report ----------------
        check("exp4_drained", exp4_q.size(), 0);
        check("exp1_drained", exp1_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
